cmos_shift_reg: RTL and testbench

Parametrised multi-channel shift/storage register modelling the 4000-series CMOS register family (CD4015B/CD4035B class) for board-level simulation. Each channel is a WIDTH-bit register with per-channel asynchronous preset, global asynchronous clear, and synchronous parallel load, bidirectional serial shift or hold. It generalises the dual D flip-flop model, which is the WIDTH=1, load-only case, and sits beside the other chip models in the board netlist.

---
 rtl/cmos_shift_reg_if.sv | 26 ++
 rtl/cmos_shift_reg.sv | 36 +++
 tb/tb_cmos_shift_reg.sv | 102 ++++++++++
 3 files changed

// File: rtl/cmos_shift_reg_if.sv
// cmos_shift_reg_if: control, data and output bundle for cmos_shift_reg
// Carries tc only when CMOS_SHIFT_REG_TC_EN is defined.
interface cmos_shift_reg_if #(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0] set;
  logic [CHANNELS-1:0] load;
  logic [CHANNELS-1:0] shift;
  logic [CHANNELS-1:0] dir;
  logic [CHANNELS-1:0] sin;
  logic [CHANNELS*WIDTH-1:0] pdata;
`ifdef CMOS_SHIFT_REG_TC_EN
  logic [CHANNELS-1:0] tc;
`endif
  logic [CHANNELS*WIDTH-1:0] q;
  logic [CHANNELS*WIDTH-1:0] nq;
  logic [CHANNELS-1:0] sout;
`ifdef CMOS_SHIFT_REG_TC_EN
  modport master (output set, load, shift, dir, sin, pdata, tc, input q, nq, sout);
  modport slave (input set, load, shift, dir, sin, pdata, tc, output q, nq, sout);
`else
  modport master (output set, load, shift, dir, sin, pdata, input q, nq, sout);
  modport slave (input set, load, shift, dir, sin, pdata, output q, nq, sout);
`endif
endinterface

// File: rtl/cmos_shift_reg.sv
// cmos_shift_reg: multi-channel 4000-series shift/storage register model
// Define CMOS_SHIFT_REG_TC_EN to add the per-channel true/complement output select.
module cmos_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 2
) (
  input logic clk,
  input logic reset,
  cmos_shift_reg_if.slave bus
);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    if (WIDTH == 1) begin : g_w1
      assign w_shl = bus.sin[c];
      assign w_shr = bus.sin[c];
    end else begin : g_wn
      assign w_shl = {r_data[WIDTH-2:0], bus.sin[c]};
      assign w_shr = {bus.sin[c], r_data[WIDTH-1:1]};
    end
    // Preset outranks the global clear so a held set[c] keeps its channel at ones.
    always_ff @(posedge clk or posedge reset or posedge bus.set[c])
      if (bus.set[c]) r_data <= '1;
      else if (reset) r_data <= '0;
      else if (bus.load[c]) r_data <= bus.pdata[c*WIDTH +: WIDTH];
      else if (bus.shift[c]) r_data <= bus.dir[c] ? w_shr : w_shl;
`ifdef CMOS_SHIFT_REG_TC_EN
    assign bus.q[c*WIDTH +: WIDTH] = bus.tc[c] ? ~r_data : r_data;
`else
    assign bus.q[c*WIDTH +: WIDTH] = r_data;
`endif
    assign bus.sout[c] = bus.dir[c] ? r_data[0] : r_data[WIDTH-1];
  end
  assign bus.nq = ~bus.q;
endmodule

// File: tb/tb_cmos_shift_reg.sv
// tb_cmos_shift_reg: directed vector bench for cmos_shift_reg (2 channels x 4 bits)
module tb_cmos_shift_reg;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  cmos_shift_reg_if #(.WIDTH(4), .CHANNELS(2)) bus ();
  cmos_shift_reg #(.WIDTH(4), .CHANNELS(2)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] load;
    logic [1:0] shift;
    logic [1:0] dir;
    logic [1:0] sin;
    logic [7:0] pdata;
    logic [7:0] q;
    logic [1:0] sout;
  } vec_t;

  vec_t v [16];

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [7:0] eq, input logic [1:0] es);
    chk({nm, "_q"}, bus.q, eq);
    chk({nm, "_nq"}, bus.nq, ~eq);
    chk({nm, "_sout"}, {6'b0, bus.sout}, {6'b0, es});
  endtask

  initial begin
    // load shift dir sin pdata q sout
    v[0]  = '{2'b01, 2'b00, 2'b00, 2'b00, 8'hA5, 8'h05, 2'b00};
    v[1]  = '{2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00};
    v[2]  = '{2'b00, 2'b01, 2'b00, 2'b01, 8'h00, 8'h01, 2'b00};
    v[3]  = '{2'b00, 2'b01, 2'b00, 2'b00, 8'h00, 8'h02, 2'b00};
    v[4]  = '{2'b00, 2'b01, 2'b00, 2'b01, 8'h00, 8'h05, 2'b00};
    v[5]  = '{2'b00, 2'b01, 2'b00, 2'b01, 8'h00, 8'h0B, 2'b01};
    v[6]  = '{2'b01, 2'b00, 2'b01, 2'b00, 8'h00, 8'h00, 2'b00};
    v[7]  = '{2'b00, 2'b01, 2'b01, 2'b01, 8'h00, 8'h08, 2'b00};
    v[8]  = '{2'b00, 2'b01, 2'b01, 2'b00, 8'h00, 8'h04, 2'b00};
    v[9]  = '{2'b00, 2'b01, 2'b01, 2'b01, 8'h00, 8'h0A, 2'b00};
    v[10] = '{2'b00, 2'b01, 2'b01, 2'b01, 8'h00, 8'h0D, 2'b01};
    v[11] = '{2'b10, 2'b00, 2'b00, 2'b00, 8'hA0, 8'hAD, 2'b11};
    v[12] = '{2'b11, 2'b11, 2'b00, 2'b11, 8'h3C, 8'h3C, 2'b01};
    v[13] = '{2'b00, 2'b00, 2'b00, 2'b11, 8'hFF, 8'h3C, 2'b01};
    v[14] = '{2'b00, 2'b10, 2'b00, 2'b10, 8'h00, 8'h7C, 2'b01};
    v[15] = '{2'b00, 2'b11, 2'b11, 2'b00, 8'h00, 8'h36, 2'b10};
    bus.set = '0; bus.load = '0; bus.shift = '0; bus.dir = '0; bus.sin = '0; bus.pdata = '0;
`ifdef CMOS_SHIFT_REG_TC_EN
    bus.tc = '0;
`endif
    @(negedge clk) reset = 1'b1;
    #1 chk_all("reset", 8'h00, 2'b00);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.load = v[i].load; bus.shift = v[i].shift; bus.dir = v[i].dir;
      bus.sin = v[i].sin; bus.pdata = v[i].pdata;
      @(posedge clk) #1 chk_all($sformatf("vec%0d", i), v[i].q, v[i].sout);
      @(negedge clk);
    end
    bus.load = '0; bus.shift = '0; bus.dir = '0;
    // set[1] asserted mid-cycle, then held across a load edge
    bus.load = 2'b10; bus.pdata = 8'hA0;
    @(posedge clk) #1 chk("set_pre_q", bus.q, 8'hA6);
    @(negedge clk) bus.set = 2'b10; bus.pdata = 8'h00;
    #1 chk("set_async_q", bus.q, 8'hF6);
    @(posedge clk) #1 chk("set_held_q", bus.q, 8'hF6);
    @(negedge clk) bus.set = 2'b00;
    #1 chk("set_release_q", bus.q, 8'hF6);
    @(posedge clk) #1 chk("set_after_q", bus.q, 8'h06);
    // set[0] together with reset
    @(negedge clk) bus.load = 2'b00; bus.set = 2'b01; reset = 1'b1;
    #1 chk_all("set_reset", 8'h0F, 2'b01);
    bus.load = 2'b11; bus.pdata = 8'h3C;
    @(posedge clk) #1 chk("set_reset_held_q", bus.q, 8'h0F);
    @(negedge clk) bus.set = 2'b00; reset = 1'b0;
    @(posedge clk) #1 chk("set_reset_after_q", bus.q, 8'h3C);
    // asynchronous clear between edges
    @(negedge clk) bus.load = 2'b00; reset = 1'b1;
    #1 chk_all("async_reset", 8'h00, 2'b00);
    @(negedge clk) reset = 1'b0;
`ifdef CMOS_SHIFT_REG_TC_EN
    bus.load = 2'b01; bus.pdata = 8'h06;
    @(posedge clk) #1 chk("tc_pre_q", bus.q, 8'h06);
    @(negedge clk) bus.load = 2'b00; bus.tc = 2'b01;
    #1 chk_all("tc_on", 8'h09, 2'b00);
    bus.tc = 2'b00;
    #1 chk_all("tc_off", 8'h06, 2'b00);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
